// File: rtl/alu_issue_if.sv
// Operand, ALU and result bundle between alu_issue_stage, its upstream/downstream
// neighbours and the external combinational ALU.
interface alu_issue_if;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] in_a;
   logic signed [31:0] in_b;
   logic [2:0]         in_op;
   logic signed [31:0] alu_a;
   logic signed [31:0] alu_b;
   logic [2:0]         alu_op;
   logic [31:0]        alu_z;
   logic               alu_ex;
   logic               out_valid;
   logic               out_ready;
   logic [31:0]        out_z;
   logic               out_ex;
   logic [2:0]         out_op;
   logic               out_illegal;
   logic [15:0]        issued_cnt;

   modport slave (
      input  in_valid, in_a, in_b, in_op, alu_z, alu_ex, out_ready,
      output in_ready, alu_a, alu_b, alu_op, out_valid, out_z, out_ex, out_op,
             out_illegal, issued_cnt
   );

   modport master (
      output in_valid, in_a, in_b, in_op, alu_z, alu_ex, out_ready,
      input  in_ready, alu_a, alu_b, alu_op, out_valid, out_z, out_ex, out_op,
             out_illegal, issued_cnt
   );
endinterface

// File: rtl/alu_issue_stage.sv
// Operand FIFO feeding an external combinational ALU, with a registered result
// stage; illegal opcodes bypass the ALU and are flagged on the output.
module alu_issue_stage #(
   parameter int DEPTH = 4
) (
   input logic        clk,
   input logic        rst_n,
   alu_issue_if.slave bus
);
   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] LAST = (AW + 1)'(DEPTH - 1);
   localparam logic [AW:0] ONE  = (AW + 1)'(1);

   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_t;

   occ_t               state;
   logic [AW:0]        count;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               rdy_p0;
   logic signed [31:0] mem_a  [DEPTH];
   logic signed [31:0] mem_b  [DEPTH];
   logic [2:0]         mem_op [DEPTH];

   logic               vld_p1;
   logic [31:0]        z_p1;
   logic               ex_p1;
   logic [2:0]         op_p1;
   logic               ill_p1;
   logic [15:0]        cnt_p1;

   logic               push;
   logic               issue;
   logic               in_ready_c;
   logic               head_legal;

   function automatic logic is_legal(input logic [2:0] op);
      case (op)
         3'b000, 3'b001, 3'b010, 3'b110, 3'b111: is_legal = 1'b1;
         default:                                is_legal = 1'b0;
      endcase
   endfunction

   // Stage p0: FIFO head presented to the ALU, handshake decode
   always_comb begin
      issue      = (state != EMPTY) && (!vld_p1 || bus.out_ready);
      in_ready_c = rdy_p0 && ((state != FULL) || issue);
      push       = bus.in_valid && in_ready_c;
      bus.alu_a  = '0;
      bus.alu_b  = '0;
      bus.alu_op = '0;
      if (state != EMPTY) begin
         bus.alu_a  = mem_a[rd_ptr];
         bus.alu_b  = mem_b[rd_ptr];
         bus.alu_op = mem_op[rd_ptr];
      end
      head_legal = is_legal(bus.alu_op);
   end

   assign bus.in_ready = in_ready_c;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]  <= bus.in_a;
         mem_b[wr_ptr]  <= bus.in_b;
         mem_op[wr_ptr] <= bus.in_op;
      end
   end

   // Occupancy tracking, pointers and the p1 result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         rdy_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         z_p1   <= '0;
         ex_p1  <= 1'b0;
         op_p1  <= '0;
         ill_p1 <= 1'b0;
         cnt_p1 <= '0;
      end else begin
         rdy_p0 <= 1'b1;
         if (push)  wr_ptr <= wr_ptr + 1'b1;
         if (issue) rd_ptr <= rd_ptr + 1'b1;

         case ({push, issue})
            2'b10: begin
               count <= count + 1'b1;
               state <= (count == LAST) ? FULL : PARTIAL;
            end
            2'b01: begin
               count <= count - 1'b1;
               state <= (count == ONE) ? EMPTY : PARTIAL;
            end
            default: ;
         endcase

         if (issue) begin
            vld_p1 <= 1'b1;
            op_p1  <= bus.alu_op;
            ill_p1 <= !head_legal;
            z_p1   <= head_legal ? bus.alu_z : 32'd0;
            ex_p1  <= head_legal ? bus.alu_ex : 1'b1;
            cnt_p1 <= cnt_p1 + 1'b1;
         end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign bus.out_valid   = vld_p1;
   assign bus.out_z       = z_p1;
   assign bus.out_ex      = ex_p1;
   assign bus.out_op      = op_p1;
   assign bus.out_illegal = ill_p1;
   assign bus.issued_cnt  = cnt_p1;
endmodule
